// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM controller slice.
package sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;
  localparam logic [2:0]  READ_PHASES       = 3'd4;
  localparam logic [2:0]  WRITE_PHASES      = 3'd2;
  localparam int          SRAM_AW           = 18;

endpackage

// File: rtl/sram_phase_timer.sv
// Wait-state counter and phase index for one multi-phase SRAM operation.
module sram_phase_timer #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       en,
  input  logic [2:0] phases,
  output logic [1:0] k,
  output logic       phase_prelast,
  output logic       phase_last,
  output logic       op_last
);

  localparam int          CW      = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] LAST    = CW'(WAIT_CYCLES - 1);
  localparam logic [CW-1:0] PRELAST = CW'(WAIT_CYCLES - 2);
  localparam logic [CW-1:0] ONE     = CW'(1);

  logic [CW-1:0] cnt_r;
  logic [1:0]    k_r;

  assign phase_last    = (cnt_r == LAST);
  assign phase_prelast = (cnt_r == PRELAST);
  assign op_last       = phase_last && ({1'b0, k_r} == (phases - 3'd1));
  assign k             = k_r;

  // Advance the wait counter; step the phase index when a phase ends
  always_ff @(posedge clk) begin
    if (rst || start) begin
      cnt_r <= '0;
      k_r   <= 2'd0;
    end else if (en) begin
      if (phase_last) begin
        cnt_r <= '0;
        k_r   <= op_last ? 2'd0 : k_r + 2'd1;
      end else begin
        cnt_r <= cnt_r + ONE;
      end
    end else begin
      cnt_r <= cnt_r;
      k_r   <= k_r;
    end
  end

endmodule

// File: rtl/sram_controller.sv
// Sequences cache line reads and word writes onto a 16-bit asynchronous
// SRAM with a fixed number of wait states per halfword access.
module sram_controller
  import sram_pkg::*;
#(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [63:0] rdata,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  state_t             state_r;
  state_t             state_next_s;
  logic [18:0]        offset_s;
  logic               unused_bits_s;
  logic               accept_s;
  logic               busy_s;
  logic               op_done_s;
  logic [2:0]         phases_s;
  logic [1:0]         k_s;
  logic               phase_prelast_s;
  logic               phase_last_s;
  logic               op_last_s;
  logic [SRAM_AW-1:0] addr_r;
  logic [47:0]        line_r;
  logic [63:0]        rdata_r;
  logic               ready_r;
  logic               we_n_r;
  logic               oe_n_r;
  logic               dq_oe_s;
  logic [15:0]        dq_out_s;

  // Offsets beyond 19 bits wrap silently
  assign offset_s      = address[18:0] - BASE_ADDR[18:0];
  assign unused_bits_s = ^{address[31:19], offset_s[1:0]};

  assign accept_s  = (state_r == ST_IDLE) && (rd_en || wr_en);
  assign busy_s    = (state_r == ST_READ) || (state_r == ST_WRITE);
  assign op_done_s = busy_s && op_last_s;
  assign phases_s  = (state_r == ST_WRITE) ? WRITE_PHASES : READ_PHASES;

  sram_phase_timer #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .start        (accept_s),
    .en           (busy_s),
    .phases       (phases_s),
    .k            (k_s),
    .phase_prelast(phase_prelast_s),
    .phase_last   (phase_last_s),
    .op_last      (op_last_s)
  );

  // Next-state selection; a write wins over a simultaneous read
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (wr_en) begin
          state_next_s = ST_WRITE;
        end else if (rd_en) begin
          state_next_s = ST_READ;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_READ, ST_WRITE: begin
        if (op_last_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, completion pulse and registered SRAM address/strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      ready_r <= 1'b0;
      we_n_r  <= 1'b1;
      oe_n_r  <= 1'b0;
      addr_r  <= '0;
    end else begin
      state_r <= state_next_s;
      ready_r <= op_done_s;
      oe_n_r  <= (state_next_s == ST_WRITE);
      if (accept_s) begin
        we_n_r <= ~wr_en;
        addr_r <= wr_en ? {offset_s[18:2], 1'b0} : {offset_s[18:3], 2'b00};
      end else begin
        // WE_N rises on each phase's last cycle so address and data are held
        we_n_r <= (state_r == ST_WRITE) ? (phase_last_s ? op_last_s : phase_prelast_s) : 1'b1;
        if (busy_s && phase_last_s && !op_last_s) begin
          addr_r <= addr_r + 18'd1;
        end else begin
          addr_r <= addr_r;
        end
      end
    end
  end

  // Capture each halfword at the end of its read phase; publish the line on the last
  always_ff @(posedge clk) begin
    if (rst) begin
      line_r  <= '0;
      rdata_r <= '0;
    end else if ((state_r == ST_READ) && phase_last_s) begin
      case (k_s)
        2'd0:    line_r[15:0]  <= SRAM_DQ;
        2'd1:    line_r[31:16] <= SRAM_DQ;
        2'd2:    line_r[47:32] <= SRAM_DQ;
        2'd3:    rdata_r       <= {SRAM_DQ, line_r};
        default: line_r        <= line_r;
      endcase
    end else begin
      line_r  <= line_r;
      rdata_r <= rdata_r;
    end
  end

  // Data bus drive follows the live write-data halfword
  always_comb begin
    dq_oe_s = (state_r == ST_WRITE);
    if (k_s == 2'd0) begin
      dq_out_s = wdata[15:0];
    end else begin
      dq_out_s = wdata[31:16];
    end
  end

  assign SRAM_DQ   = dq_oe_s ? dq_out_s : 16'hzzzz;
  assign SRAM_ADDR = addr_r;
  assign SRAM_WE_N = we_n_r;
  assign SRAM_OE_N = oe_n_r;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign ready     = ready_r;
  assign rdata     = rdata_r;

endmodule
